// File: rtl/save_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : save_ram_arbiter_if
// Purpose : Cartridge mapper port and save_handler bk_* port of the save RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface save_ram_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 16
);
   logic              bk_wr;
   logic [ADDR_W-1:0] bk_addr;
   logic [DATA_W-1:0] bk_data;
   logic [DATA_W-1:0] bk_q;

   logic              cart_req;
   logic              cart_we;
   logic [1:0]        cart_be;
   logic [ADDR_W-1:0] cart_addr;
   logic [DATA_W-1:0] cart_wdata;
   logic              cart_ack;
   logic [DATA_W-1:0] cart_rdata;

   modport master (
      output bk_wr, bk_addr, bk_data,
      output cart_req, cart_we, cart_be, cart_addr, cart_wdata,
      input  bk_q, cart_ack, cart_rdata
   );

   modport slave (
      input  bk_wr, bk_addr, bk_data,
      input  cart_req, cart_we, cart_be, cart_addr, cart_wdata,
      output bk_q, cart_ack, cart_rdata
   );
endinterface
`default_nettype wire

// File: rtl/save_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : save_ram_arbiter
// Purpose : Shares the single-port backup SRAM between the mapper and save_handler.
// Revision: 1.0 - initial release
// ============================================================================
module save_ram_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              cart_download,
   save_ram_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [1:0]        ram_be,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_q,
   output logic              dirty,
   input  logic              dirty_clr,
   output logic              bk_overflow
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CART    = 2'd1,
      ST_BK_SLOT = 2'd2
   } state_t;

   localparam logic [2:0] c_cnt_last = 3'(RD_LATENCY);
   localparam logic [1:0] c_tag_none = 2'b00;
   localparam logic [1:0] c_tag_bk   = 2'b01;
   localparam logic [1:0] c_tag_cart = 2'b10;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_cnt, w_cnt_nxt;

   logic              r_bk_wr_d;
   logic              w_bk_rise;
   logic              r_pend;
   logic [ADDR_W-1:0] r_pend_addr;
   logic [DATA_W-1:0] r_pend_data;

   logic              w_commit;
   logic              w_dirty_set;
   logic              w_ack;
   logic [ADDR_W-1:0] w_ram_addr_nxt;
   logic              w_ram_we_nxt;
   logic [1:0]        w_ram_be_nxt;
   logic [DATA_W-1:0] w_ram_wdata_nxt;
   logic [1:0]        w_tag_nxt;

   // r_ram_tag travels with ram_addr; the shift register delays it to line up with ram_q.
   logic [1:0]        r_ram_tag;
   logic [1:0]        r_tag_sr [RD_LATENCY];
   logic [1:0]        w_tag_ret;

   assign w_bk_rise = bus.bk_wr & ~r_bk_wr_d;
   assign w_tag_ret = r_tag_sr[RD_LATENCY-1];

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_commit        = 1'b0;
      w_dirty_set     = 1'b0;
      w_ack           = 1'b0;
      w_ram_addr_nxt  = ram_addr;
      w_ram_we_nxt    = 1'b0;
      w_ram_be_nxt    = 2'b00;
      w_ram_wdata_nxt = ram_wdata;
      w_tag_nxt       = c_tag_none;

      if (r_pend && (r_state == ST_IDLE || r_state == ST_BK_SLOT)) begin
         w_commit        = 1'b1;
         w_ram_addr_nxt  = r_pend_addr;
         w_ram_we_nxt    = 1'b1;
         w_ram_be_nxt    = 2'b11;
         w_ram_wdata_nxt = r_pend_data;
      end else if (r_state == ST_IDLE && bus.cart_req && !cart_download) begin
         w_ram_addr_nxt  = bus.cart_addr;
         w_ram_we_nxt    = bus.cart_we;
         w_ram_be_nxt    = bus.cart_we ? bus.cart_be : 2'b00;
         w_ram_wdata_nxt = bus.cart_wdata;
         w_tag_nxt       = bus.cart_we ? c_tag_none : c_tag_cart;
         w_dirty_set     = bus.cart_we;
         w_state_nxt     = ST_CART;
         w_cnt_nxt       = 3'd0;
      end else if (r_state != ST_CART) begin
         w_ram_addr_nxt  = bus.bk_addr;
         w_tag_nxt       = c_tag_bk;
      end

      case (r_state)
         ST_IDLE: ;
         ST_CART: begin
            if (r_cnt == c_cnt_last) begin
               w_ack       = 1'b1;
               w_state_nxt = ST_BK_SLOT;
               w_cnt_nxt   = 3'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 3'd1;
            end
         end
         ST_BK_SLOT: begin
            if (r_cnt == c_cnt_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 3'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 3'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A rise that lands on the commit cycle loses nothing, so it is not an overflow.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_bk_wr_d   <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= '0;
         bk_overflow <= 1'b0;
      end else begin
         r_bk_wr_d <= bus.bk_wr;
         if (w_bk_rise) begin
            r_pend      <= 1'b1;
            r_pend_addr <= bus.bk_addr;
            r_pend_data <= bus.bk_data;
            if (r_pend && !w_commit) begin
               bk_overflow <= 1'b1;
            end
         end else if (w_commit) begin
            r_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_be    <= 2'b00;
         ram_wdata <= '0;
         r_ram_tag <= c_tag_none;
         for (int i = 0; i < RD_LATENCY; i++) begin
            r_tag_sr[i] <= c_tag_none;
         end
      end else begin
         ram_addr    <= w_ram_addr_nxt;
         ram_we      <= w_ram_we_nxt;
         ram_be      <= w_ram_be_nxt;
         ram_wdata   <= w_ram_wdata_nxt;
         r_ram_tag   <= w_tag_nxt;
         r_tag_sr[0] <= r_ram_tag;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag_sr[i] <= r_tag_sr[i-1];
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bus.bk_q       <= '0;
         bus.cart_ack   <= 1'b0;
         bus.cart_rdata <= '0;
      end else begin
         bus.cart_ack <= w_ack;
         if (w_tag_ret == c_tag_bk) begin
            bus.bk_q <= ram_q;
         end
         if (w_tag_ret == c_tag_cart) begin
            bus.cart_rdata <= ram_q;
         end
      end
   end

   // Set beats clear; a ROM download overrides both.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dirty <= 1'b0;
      end else if (cart_download) begin
         dirty <= 1'b0;
      end else if (w_dirty_set) begin
         dirty <= 1'b1;
      end else if (dirty_clr) begin
         dirty <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_save_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_save_ram_arbiter
// Purpose : Directed self-checking bench for save_ram_arbiter with a behavioural SRAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_save_ram_arbiter;
   localparam int ADDR_W = 17;
   localparam int DATA_W = 16;
   localparam int RD     = 2;

   logic              clk_sys       = 1'b0;
   logic              reset_n       = 1'b0;
   logic              cart_download = 1'b0;
   logic              dirty_clr     = 1'b0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [1:0]        ram_be;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_q;
   logic              dirty;
   logic              bk_overflow;

   logic              bd_we   = 1'b0;
   logic [9:0]        bd_addr = '0;
   logic [15:0]       bd_data = '0;
   logic [15:0]       mem    [1024];
   logic [15:0]       q_pipe [RD];

   int                n_cmp = 0;
   int                n_err = 0;
   logic [15:0]       rd;
   int                lat;
   int                a0, a1, m, acks;

   save_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   save_ram_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD)
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .cart_download (cart_download),
      .bus           (bus),
      .ram_addr      (ram_addr),
      .ram_we        (ram_we),
      .ram_be        (ram_be),
      .ram_wdata     (ram_wdata),
      .ram_q         (ram_q),
      .dirty         (dirty),
      .dirty_clr     (dirty_clr),
      .bk_overflow   (bk_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // SRAM: ram_q shows mem[ram_addr] RD cycles after ram_addr is presented.
   always @(posedge clk_sys) begin
      q_pipe[0] <= mem[ram_addr[9:0]];
      for (int i = 1; i < RD; i++) begin
         q_pipe[i] <= q_pipe[i-1];
      end
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (ram_we) begin
         if (ram_be[0]) mem[ram_addr[9:0]][7:0]  <= ram_wdata[7:0];
         if (ram_be[1]) mem[ram_addr[9:0]][15:8] <= ram_wdata[15:8];
      end
   end
   assign ram_q = q_pipe[RD-1];

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ram_poke(input logic [9:0] addr, input logic [15:0] data);
      bd_we   = 1'b1;
      bd_addr = addr;
      bd_data = data;
      tick();
      bd_we   = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // lat = cycles from the request cycle to the ack cycle, -1 on timeout.
   task automatic cart_xact(input logic we, input logic [1:0] be, input logic [16:0] addr,
                            input logic [15:0] wd, input logic clr,
                            output logic [15:0] rdata, output int latency);
      bus.cart_req   = 1'b1;
      bus.cart_we    = we;
      bus.cart_be    = be;
      bus.cart_addr  = addr;
      bus.cart_wdata = wd;
      dirty_clr      = clr;
      latency        = -1;
      rdata          = '0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         dirty_clr = 1'b0;
         if (bus.cart_ack) begin
            latency = i;
            rdata   = bus.cart_rdata;
            break;
         end
      end
      bus.cart_req = 1'b0;
      bus.cart_we  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus.bk_wr      = 1'b0;
      bus.bk_addr    = 17'h00010;
      bus.bk_data    = '0;
      bus.cart_req   = 1'b0;
      bus.cart_we    = 1'b0;
      bus.cart_be    = 2'b00;
      bus.cart_addr  = '0;
      bus.cart_wdata = '0;

      // 1. reset and bk_q refresh
      ram_poke(10'h010, 16'hBEEF);
      ram_poke(10'h100, 16'hFFFF);
      ram_poke(10'h020, 16'h5555);
      ram_poke(10'h040, 16'h0C0C);
      ram_poke(10'h005, 16'h0000);
      ram_poke(10'h030, 16'h0000);
      check_eq("rst_ctl", 32'({ram_we, ram_be, dirty, bk_overflow, bus.cart_ack}), 32'h0);
      check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
      check_eq("rst_ram_wdata", 32'(ram_wdata), 32'h0);
      check_eq("rst_bk_q", 32'(bus.bk_q), 32'h0);
      check_eq("rst_cart_rdata", 32'(bus.cart_rdata), 32'h0);
      reset_n = 1'b1;
      ticks(4);
      check_eq("bk_q_after_reset", 32'(bus.bk_q), 32'hBEEF);
      check_eq("idle_ctl", 32'({ram_we, dirty, bk_overflow, bus.cart_ack}), 32'h0);

      // 2. cart write with byte enable, then read back
      cart_xact(1'b1, 2'b01, 17'h00100, 16'h1234, 1'b0, rd, lat);
      check_eq("wr_latency", 32'(lat), 32'd4);
      check_eq("wr_mem", 32'(mem[10'h100]), 32'hFF34);
      check_eq("wr_dirty", 32'(dirty), 32'h1);
      tick();
      check_eq("ack_pulse", 32'(bus.cart_ack), 32'h0);
      ticks(3);
      cart_xact(1'b0, 2'b00, 17'h00100, 16'h0000, 1'b0, rd, lat);
      check_eq("rd_latency", 32'(lat), 32'd4);
      check_eq("rd_data", 32'(rd), 32'hFF34);
      ticks(4);
      dirty_clr = 1'b1;
      tick();
      dirty_clr = 1'b0;
      check_eq("dirty_clr_alone", 32'(dirty), 32'h0);

      // 3. bk write strobe during a cart read
      fork
         cart_xact(1'b0, 2'b00, 17'h00040, 16'h0000, 1'b0, rd, lat);
         begin
            tick();
            bus.bk_wr   = 1'b1;
            bus.bk_addr = 17'h00005;
            bus.bk_data = 16'hA5A5;
            ticks(3);
            bus.bk_wr   = 1'b0;
         end
      join
      ticks(8);
      check_eq("bkwr_cart_lat", 32'(lat), 32'd4);
      check_eq("bkwr_cart_data", 32'(rd), 32'h0C0C);
      check_eq("bkwr_mem", 32'(mem[10'h005]), 32'hA5A5);
      check_eq("bkwr_bk_q", 32'(bus.bk_q), 32'hA5A5);
      check_eq("bkwr_dirty", 32'(dirty), 32'h0);
      check_eq("bkwr_no_ovf", 32'(bk_overflow), 32'h0);

      // 4. back-to-back requests and bk_q tracking
      ticks(4);
      a0 = -1; a1 = -1; m = -1;
      bus.cart_req  = 1'b1;
      bus.cart_we   = 1'b0;
      bus.cart_addr = 17'h00040;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (a0 >= 0 && m < 0 && bus.bk_q == 16'h5555) m = i;
         if (bus.cart_ack) begin
            if (a0 < 0) begin
               a0 = i;
               bus.bk_addr = 17'h00020;
            end else begin
               a1 = i;
               rd = bus.cart_rdata;
               break;
            end
         end
      end
      bus.cart_req = 1'b0;
      check_eq("b2b_first_ack", 32'(a0), 32'd4);
      check_eq("b2b_ack_spacing", 32'(a1 - a0), 32'd7);
      check_eq("b2b_rdata", 32'(rd), 32'h0C0C);
      check_eq("bk_q_track_le8", 32'(m >= 0 && (m - a0) <= 8), 32'h1);

      // 5. dirty set/clear/download
      ticks(4);
      cart_xact(1'b1, 2'b10, 17'h00100, 16'hAB00, 1'b0, rd, lat);
      check_eq("be_hi_mem", 32'(mem[10'h100]), 32'hAB34);
      check_eq("dirty_set", 32'(dirty), 32'h1);
      ticks(4);
      cart_xact(1'b1, 2'b11, 17'h00100, 16'h7777, 1'b1, rd, lat);
      check_eq("dirty_set_wins", 32'(dirty), 32'h1);
      check_eq("be_full_mem", 32'(mem[10'h100]), 32'h7777);
      ticks(4);
      dirty_clr = 1'b1;
      tick();
      dirty_clr = 1'b0;
      check_eq("dirty_clr", 32'(dirty), 32'h0);
      cart_xact(1'b1, 2'b01, 17'h00100, 16'h0011, 1'b0, rd, lat);
      check_eq("dirty_reset_again", 32'(dirty), 32'h1);
      ticks(4);
      cart_download = 1'b1;
      tick();
      check_eq("download_clears_dirty", 32'(dirty), 32'h0);
      acks = 0;
      bus.cart_req   = 1'b1;
      bus.cart_we    = 1'b1;
      bus.cart_be    = 2'b11;
      bus.cart_addr  = 17'h00100;
      bus.cart_wdata = 16'hDEAD;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.cart_ack) acks++;
      end
      bus.cart_req = 1'b0;
      bus.cart_we  = 1'b0;
      check_eq("download_no_ack", 32'(acks), 32'd0);
      check_eq("download_mem_kept", 32'(mem[10'h100]), 32'h7711);
      check_eq("download_dirty", 32'(dirty), 32'h0);
      cart_download = 1'b0;

      // 6. overflow, then reset mid-CART
      ticks(4);
      fork
         cart_xact(1'b0, 2'b00, 17'h00040, 16'h0000, 1'b0, rd, lat);
         begin
            tick();
            bus.bk_wr   = 1'b1;
            bus.bk_addr = 17'h00030;
            bus.bk_data = 16'h1111;
            tick();
            bus.bk_wr   = 1'b0;
            tick();
            bus.bk_wr   = 1'b1;
            bus.bk_data = 16'h2222;
            ticks(3);
            bus.bk_wr   = 1'b0;
         end
      join
      ticks(4);
      check_eq("ovf_cart_data", 32'(rd), 32'h0C0C);
      check_eq("ovf_flag", 32'(bk_overflow), 32'h1);
      check_eq("ovf_mem", 32'(mem[10'h030]), 32'h2222);

      ticks(4);
      acks = 0;
      bus.cart_req  = 1'b1;
      bus.cart_we   = 1'b0;
      bus.cart_addr = 17'h00040;
      ticks(2);
      reset_n = 1'b0;
      #1;
      check_eq("midrst_ctl", 32'({ram_we, ram_be, dirty, bk_overflow, bus.cart_ack}), 32'h0);
      check_eq("midrst_ram_addr", 32'(ram_addr), 32'h0);
      check_eq("midrst_ram_wdata", 32'(ram_wdata), 32'h0);
      check_eq("midrst_bk_q", 32'(bus.bk_q), 32'h0);
      check_eq("midrst_cart_rdata", 32'(bus.cart_rdata), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.cart_ack) acks++;
      end
      bus.cart_req = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.cart_ack) acks++;
      end
      check_eq("midrst_no_ack", 32'(acks), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
